// File: rtl/stack_access_arbiter.sv
// rtl/stack_access_arbiter.sv - LIFO stack shared by two requesters through a round-robin IDLE/EXEC/RESP sequencer
// Optional peek operation (a_peek/b_peek ports) enabled by defining STACK_ARB_PEEK_EN.
module stack_access_arbiter #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic             a_push,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_ack,
  output logic [WIDTH-1:0] a_rdata,
  output logic             a_err,
  input  logic             b_req,
  input  logic             b_push,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_ack,
  output logic [WIDTH-1:0] b_rdata,
  output logic             b_err,
`ifdef STACK_ARB_PEEK_EN
  input  logic             a_peek,
  input  logic             b_peek,
`endif
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty,
  output logic             busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_sp;
  logic [AW:0]      r_level;
  logic             r_full;
  logic             r_empty;
  logic             r_last_b;
  logic             r_win_b;
  logic             r_op_push;
  logic             r_op_peek;
  logic [WIDTH-1:0] r_wdata;
  logic             r_a_ack;
  logic             r_b_ack;
  logic [WIDTH-1:0] r_a_rdata;
  logic [WIDTH-1:0] r_b_rdata;
  logic             r_a_err;
  logic             r_b_err;

  logic             w_a_peek;
  logic             w_b_peek;
  logic             w_any_req;
  logic             w_grant_b;
  logic [AW-1:0]    w_top_idx;
  logic [AW:0]      w_sp_nxt;
  logic [WIDTH-1:0] w_rsp_rdata;
  logic             w_rsp_err;
  logic             w_do_write;

`ifdef STACK_ARB_PEEK_EN
  assign w_a_peek = a_peek;
  assign w_b_peek = b_peek;
`else
  assign w_a_peek = 1'b0;
  assign w_b_peek = 1'b0;
`endif

  // B wins only when A is absent or A was the last one served.
  assign w_any_req  = a_req | b_req;
  assign w_grant_b  = b_req & (~a_req | ~r_last_b);
  assign w_top_idx  = r_sp[AW-1:0] - AW'(1);
  assign w_do_write = r_op_push & ~r_op_peek & ~r_full;

  always_comb begin
    w_sp_nxt    = r_sp;
    w_rsp_rdata = '0;
    w_rsp_err   = 1'b0;
    if (r_op_peek) begin
      if (r_empty) w_rsp_err = 1'b1;
      else         w_rsp_rdata = r_mem[w_top_idx];
    end else if (r_op_push) begin
      if (r_full) w_rsp_err = 1'b1;
      else        w_sp_nxt = r_sp + (AW+1)'(1);
    end else begin
      if (r_empty) begin
        w_rsp_err = 1'b1;
      end else begin
        w_sp_nxt    = r_sp - (AW+1)'(1);
        w_rsp_rdata = r_mem[w_top_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Storage is never reset; the stack pointer alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && r_state == ST_EXEC && w_do_write) r_mem[r_sp[AW-1:0]] <= r_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp      <= '0;
      r_level   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_last_b  <= 1'b1;
      r_win_b   <= 1'b0;
      r_op_push <= 1'b0;
      r_op_peek <= 1'b0;
      r_wdata   <= '0;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
      r_a_err   <= 1'b0;
      r_b_err   <= 1'b0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_win_b   <= w_grant_b;
            r_last_b  <= w_grant_b;
            r_op_push <= w_grant_b ? b_push   : a_push;
            r_op_peek <= w_grant_b ? w_b_peek : w_a_peek;
            r_wdata   <= w_grant_b ? b_wdata  : a_wdata;
          end
        end
        ST_EXEC: begin
          r_sp    <= w_sp_nxt;
          r_level <= w_sp_nxt;
          r_full  <= (w_sp_nxt == LVL_FULL);
          r_empty <= (w_sp_nxt == '0);
          if (r_win_b) begin
            r_b_ack   <= 1'b1;
            r_b_rdata <= w_rsp_rdata;
            r_b_err   <= w_rsp_err;
          end else begin
            r_a_ack   <= 1'b1;
            r_a_rdata <= w_rsp_rdata;
            r_a_err   <= w_rsp_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign a_ack   = r_a_ack;
  assign a_rdata = r_a_rdata;
  assign a_err   = r_a_err;
  assign b_ack   = r_b_ack;
  assign b_rdata = r_b_rdata;
  assign b_err   = r_b_err;
  assign level   = r_level;
  assign full    = r_full;
  assign empty   = r_empty;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_stack_access_arbiter.sv
// tb/tb_stack_access_arbiter.sv - randomized and directed bench for stack_access_arbiter against a queue-based stack model
module tb_stack_access_arbiter;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_req, a_push, b_req, b_push;
  logic [WIDTH-1:0] a_wdata, b_wdata;
  logic             a_ack, a_err, b_ack, b_err;
  logic [WIDTH-1:0] a_rdata, b_rdata;
  logic [4:0]       level;
  logic             full, empty, busy;
`ifdef STACK_ARB_PEEK_EN
  logic             a_peek, b_peek;
`endif

  always #5 clk = ~clk;

  stack_access_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_push(a_push), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_push(b_push), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
`ifdef STACK_ARB_PEEK_EN
    .a_peek(a_peek), .b_peek(b_peek),
`endif
    .level(level), .full(full), .empty(empty), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue holds the stack, index 0 = A, 1 = B.
  logic [7:0] stk[$];
  logic [7:0] m_rd  [2];
  logic       m_err [2];
  bit         m_last_b;

  logic [7:0] e_rd [2], e_oth_rd [2];
  logic       e_err[2], e_oth_err[2], e_full[2], e_empty[2];
  logic [4:0] e_lvl[2];
  int         e_cyc[2];

  logic [7:0] o_rd [2], o_oth_rd [2];
  logic       o_err[2], o_oth_err[2], o_full[2], o_empty[2];
  logic [4:0] o_lvl[2];
  int         o_cyc[2], o_nack[2];
  logic       o_busy_after;
  bit         o_timeout;

  task automatic model_exec(input int op, input logic [7:0] d, output logic [7:0] rd, output logic err);
    rd  = 8'h00;
    err = 1'b0;
    if (op == 1) begin
      if (stk.size() == DEPTH) err = 1'b1;
      else stk.push_back(d);
    end else if (op == 0) begin
      if (stk.size() == 0) err = 1'b1;
      else rd = stk.pop_back();
    end else begin
      if (stk.size() == 0) err = 1'b1;
      else rd = stk[$];
    end
  endtask

  task automatic model_pair(input bit a_on, input int aop, input logic [7:0] ad,
                            input bit b_on, input int bop, input logic [7:0] bd);
    int         order[$];
    int         ops[2];
    logic [7:0] ds[2];
    logic [7:0] rd;
    logic       err;
    ops[0] = aop; ops[1] = bop; ds[0] = ad; ds[1] = bd;
    if (a_on && b_on) begin
      if (m_last_b) order = '{0, 1};
      else          order = '{1, 0};
    end else if (a_on) order = '{0};
    else               order = '{1};
    foreach (order[k]) begin
      int r;
      r = order[k];
      model_exec(ops[r], ds[r], rd, err);
      m_rd[r]      = rd;
      m_err[r]     = err;
      e_rd[r]      = rd;
      e_err[r]     = err;
      e_lvl[r]     = 5'(stk.size());
      e_full[r]    = (stk.size() == DEPTH);
      e_empty[r]   = (stk.size() == 0);
      e_oth_rd[r]  = m_rd[1-r];
      e_oth_err[r] = m_err[1-r];
      e_cyc[r]     = 2 + 3 * k;
      m_last_b     = (r == 1);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0; a_push = 1'b0; b_push = 1'b0;
    a_wdata = '0; b_wdata = '0;
`ifdef STACK_ARB_PEEK_EN
    a_peek = 1'b0; b_peek = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stk.delete();
    m_rd = '{8'h00, 8'h00};
    m_err = '{1'b0, 1'b0};
    m_last_b = 1'b1;
  endtask

  task automatic run_ops(input bit a_on, input int aop, input logic [7:0] ad,
                         input bit b_on, input int bop, input logic [7:0] bd);
    int cyc;
    o_nack = '{0, 0};
    o_cyc  = '{0, 0};
    a_req = a_on; a_push = (aop == 1); a_wdata = ad;
    b_req = b_on; b_push = (bop == 1); b_wdata = bd;
`ifdef STACK_ARB_PEEK_EN
    a_peek = (aop == 2); b_peek = (bop == 2);
`endif
    cyc = 0;
    while (((a_on && o_nack[0] == 0) || (b_on && o_nack[1] == 0)) && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (a_ack) begin
        o_nack[0]++; o_cyc[0] = cyc; o_rd[0] = a_rdata; o_err[0] = a_err;
        o_lvl[0] = level; o_full[0] = full; o_empty[0] = empty;
        o_oth_rd[0] = b_rdata; o_oth_err[0] = b_err;
        a_req = 1'b0;
      end
      if (b_ack) begin
        o_nack[1]++; o_cyc[1] = cyc; o_rd[1] = b_rdata; o_err[1] = b_err;
        o_lvl[1] = level; o_full[1] = full; o_empty[1] = empty;
        o_oth_rd[1] = a_rdata; o_oth_err[1] = a_err;
        b_req = 1'b0;
      end
    end
    o_timeout = (a_on && o_nack[0] == 0) || (b_on && o_nack[1] == 0);
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    if (a_ack) o_nack[0]++;
    if (b_ack) o_nack[1]++;
    o_busy_after = busy;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({a_ack, b_ack, a_err, b_err, full, busy, empty} !== 7'b0000001) begin
      bad++;
      $display("FAIL reset_flags: got %b expected 0000001", {a_ack, b_ack, a_err, b_err, full, busy, empty});
    end
    total++;
    if ({a_rdata, b_rdata} !== 16'h0000) begin
      bad++; $display("FAIL reset_rdata: got %h expected 0000", {a_rdata, b_rdata});
    end
    total++;
    if (level !== 5'd0) begin
      bad++; $display("FAIL reset_level: got %0d expected 0", level);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    run_ops(1, 1, 8'h11, 0, 0, 8'h00);
    total++;
    if (o_cyc[0] !== 2) begin
      bad++; $display("FAIL basic_latency: got %0d expected 2", o_cyc[0]);
    end
    run_ops(1, 1, 8'h22, 0, 0, 8'h00);
    total++;
    if (o_rd[0] !== 8'h00 || o_lvl[0] !== 5'd2) begin
      bad++; $display("FAIL basic_push_resp: got rd=%h lvl=%0d expected rd=00 lvl=2", o_rd[0], o_lvl[0]);
    end
    run_ops(1, 0, 8'h00, 0, 0, 8'h00);
    total++;
    if (o_timeout || o_rd[0] !== 8'h22 || o_err[0] !== 1'b0 || o_lvl[0] !== 5'd1) begin
      bad++;
      $display("FAIL basic_pop: got to=%0d rd=%h err=%b lvl=%0d expected to=0 rd=22 err=0 lvl=1",
               o_timeout, o_rd[0], o_err[0], o_lvl[0]);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    run_ops(1, 1, 8'hAA, 1, 1, 8'hBB);
    total++;
    if (o_cyc[0] !== 2 || o_cyc[1] !== 5) begin
      bad++; $display("FAIL contention_order: got a=%0d b=%0d expected a=2 b=5", o_cyc[0], o_cyc[1]);
    end
    total++;
    if (o_nack[0] !== 1 || o_nack[1] !== 1 || o_lvl[1] !== 5'd2) begin
      bad++; $display("FAIL contention_acks: got na=%0d nb=%0d lvl=%0d expected 1 1 2", o_nack[0], o_nack[1], o_lvl[1]);
    end
    run_ops(1, 0, 8'h00, 0, 0, 8'h00);
    total++;
    if (o_rd[0] !== 8'hBB) begin
      bad++; $display("FAIL contention_pop1: got %h expected bb", o_rd[0]);
    end
    run_ops(0, 0, 8'h00, 1, 0, 8'h00);
    total++;
    if (o_rd[1] !== 8'hAA || o_oth_rd[1] !== 8'hBB) begin
      bad++; $display("FAIL contention_pop2: got rd=%h a_hold=%h expected rd=aa a_hold=bb", o_rd[1], o_oth_rd[1]);
    end
  endtask

  task automatic test_overflow();
    int errs;
    apply_reset();
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      run_ops(1, 1, 8'(i), 0, 0, 8'h00);
      if (o_err[0] !== 1'b0 || o_timeout) errs++;
    end
    total++;
    if (errs != 0 || full !== 1'b1) begin
      bad++; $display("FAIL overflow_fill: got errs=%0d full=%b expected errs=0 full=1", errs, full);
    end
    run_ops(1, 1, 8'hFF, 0, 0, 8'h00);
    total++;
    if (o_err[0] !== 1'b1 || o_full[0] !== 1'b1 || o_lvl[0] !== 5'd16) begin
      bad++; $display("FAIL overflow_17th: got err=%b full=%b lvl=%0d expected 1 1 16", o_err[0], o_full[0], o_lvl[0]);
    end
    run_ops(1, 0, 8'h00, 0, 0, 8'h00);
    total++;
    if (o_rd[0] !== 8'h0F || o_err[0] !== 1'b0 || o_lvl[0] !== 5'd15 || o_full[0] !== 1'b0) begin
      bad++;
      $display("FAIL overflow_pop: got rd=%h err=%b lvl=%0d full=%b expected 0f 0 15 0", o_rd[0], o_err[0], o_lvl[0], o_full[0]);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    run_ops(0, 0, 8'h00, 1, 0, 8'h00);
    total++;
    if (o_rd[1] !== 8'h00 || o_err[1] !== 1'b1 || o_lvl[1] !== 5'd0 || o_empty[1] !== 1'b1) begin
      bad++;
      $display("FAIL underflow_pop: got rd=%h err=%b lvl=%0d empty=%b expected 00 1 0 1", o_rd[1], o_err[1], o_lvl[1], o_empty[1]);
    end
    total++;
    if (o_oth_err[1] !== 1'b0 || o_nack[0] !== 0) begin
      bad++; $display("FAIL underflow_loser: got a_err=%b a_acks=%0d expected 0 0", o_oth_err[1], o_nack[0]);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    apply_reset();
    a_req = 1'b1; a_push = 1'b1; a_wdata = 8'h55;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL resetmid_exec: got busy=%b expected 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    acks = a_ack;
    total++;
    if (level !== 5'd0 || empty !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL resetmid_state: got lvl=%0d empty=%b busy=%b expected 0 1 0", level, empty, busy);
    end
    a_req = 1'b0; rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      acks += a_ack;
    end
    total++;
    if (acks != 0) begin
      bad++; $display("FAIL resetmid_noack: got %0d acks expected 0", acks);
    end
    run_ops(1, 0, 8'h00, 0, 0, 8'h00);
    total++;
    if (o_err[0] !== 1'b1 || o_rd[0] !== 8'h00) begin
      bad++; $display("FAIL resetmid_pop: got err=%b rd=%h expected 1 00", o_err[0], o_rd[0]);
    end
  endtask

`ifdef STACK_ARB_PEEK_EN
  task automatic test_peek();
    apply_reset();
    run_ops(1, 1, 8'h3C, 0, 0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      run_ops(1, 2, 8'h00, 0, 0, 8'h00);
      total++;
      if (o_rd[0] !== 8'h3C || o_err[0] !== 1'b0 || o_lvl[0] !== 5'd1) begin
        bad++; $display("FAIL peek_%0d: got rd=%h err=%b lvl=%0d expected 3c 0 1", i, o_rd[0], o_err[0], o_lvl[0]);
      end
    end
    run_ops(1, 0, 8'h00, 0, 0, 8'h00);
    run_ops(1, 2, 8'h00, 0, 0, 8'h00);
    total++;
    if (o_err[0] !== 1'b1 || o_rd[0] !== 8'h00) begin
      bad++; $display("FAIL peek_empty: got err=%b rd=%h expected 1 00", o_err[0], o_rd[0]);
    end
  endtask
`endif

  task automatic test_random();
    bit         a_on, b_on, both;
    int         aop, bop;
    logic [7:0] ad, bd;
    bit         on[2];
    apply_reset();
    for (int it = 0; it < 120; it++) begin
      both = ($urandom_range(0, 9) < 3);
      a_on = both || ($urandom_range(0, 1) == 1);
      b_on = both || !a_on;
      aop  = ($urandom_range(0, 9) < 6) ? 1 : 0;
      bop  = ($urandom_range(0, 9) < 6) ? 1 : 0;
`ifdef STACK_ARB_PEEK_EN
      if ($urandom_range(0, 9) == 0) aop = 2;
      if ($urandom_range(0, 9) == 0) bop = 2;
`endif
      ad = 8'($urandom);
      bd = 8'($urandom);
      run_ops(a_on, aop, ad, b_on, bop, bd);
      model_pair(a_on, aop, ad, b_on, bop, bd);
      on[0] = a_on; on[1] = b_on;
      total++;
      if (o_timeout || o_busy_after !== 1'b0) begin
        bad++; $display("FAIL rand_%0d_done: got timeout=%0d busy=%b expected 0 0", it, o_timeout, o_busy_after);
      end
      for (int r = 0; r < 2; r++) begin
        total++;
        if (o_nack[r] != int'(on[r])) begin
          bad++; $display("FAIL rand_%0d_acks%0d: got %0d expected %0d", it, r, o_nack[r], on[r]);
        end
        if (on[r]) begin
          total++;
          if (o_rd[r] !== e_rd[r] || o_err[r] !== e_err[r] || o_cyc[r] != e_cyc[r]) begin
            bad++;
            $display("FAIL rand_%0d_resp%0d: got rd=%h err=%b cyc=%0d expected rd=%h err=%b cyc=%0d",
                     it, r, o_rd[r], o_err[r], o_cyc[r], e_rd[r], e_err[r], e_cyc[r]);
          end
          total++;
          if (o_lvl[r] !== e_lvl[r] || o_full[r] !== e_full[r] || o_empty[r] !== e_empty[r]) begin
            bad++;
            $display("FAIL rand_%0d_occ%0d: got lvl=%0d full=%b empty=%b expected lvl=%0d full=%b empty=%b",
                     it, r, o_lvl[r], o_full[r], o_empty[r], e_lvl[r], e_full[r], e_empty[r]);
          end
          total++;
          if (o_oth_rd[r] !== e_oth_rd[r] || o_oth_err[r] !== e_oth_err[r]) begin
            bad++;
            $display("FAIL rand_%0d_hold%0d: got rd=%h err=%b expected rd=%h err=%b",
                     it, r, o_oth_rd[r], o_oth_err[r], e_oth_rd[r], e_oth_err[r]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_contention();
    test_overflow();
    test_underflow();
    test_reset_mid();
`ifdef STACK_ARB_PEEK_EN
    test_peek();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
